// File: rtl/seg_bcd_counter_if.sv
// rtl/seg_bcd_counter_if.sv - control inputs and display outputs of seg_bcd_counter
interface seg_bcd_counter_if;
  logic       clk_1hz;
  logic       en;
  logic       clr;
  logic       up;
  logic [7:0] seg;
  logic [1:0] dig_sel;
  logic       carry;

  modport master (
    output clk_1hz, en, clr, up,
    input  seg, dig_sel, carry
  );

  modport slave (
    input  clk_1hz, en, clr, up,
    output seg, dig_sel, carry
  );
endinterface

// File: rtl/seg_bcd_counter.sv
// rtl/seg_bcd_counter.sv - two-digit BCD up/down seconds counter with multiplexed seven-segment scan
// Optional macro SEG_LZ_BLANK_EN blanks the tens digit while it is zero.
module seg_bcd_counter #(
  parameter int SCAN_DIV    = 12000,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_bcd_counter_if.slave bus
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  SEG_OFF   = SEG_ACT_LOW ? 8'hFF : 8'h00;

  logic        r_prev;
  logic [3:0]  r_ones;
  logic [3:0]  r_tens;
  logic        r_carry;
  logic [15:0] r_scan_cnt;
  logic        r_sel;
  logic [7:0]  r_seg;
  logic [1:0]  r_dig_sel;

  logic        w_tick;
  logic [3:0]  w_ones_nxt;
  logic [3:0]  w_tens_nxt;
  logic        w_carry_nxt;
  logic [3:0]  w_digit;
  logic [7:0]  w_seg_hi;
  logic [7:0]  w_seg_out;

  // r_prev resets high so a clk_1hz already high at release is not a tick
  assign w_tick = bus.clk_1hz & ~r_prev;

  always_comb begin
    w_ones_nxt  = r_ones;
    w_tens_nxt  = r_tens;
    w_carry_nxt = 1'b0;
    if (bus.clr) begin
      w_ones_nxt = 4'd0;
      w_tens_nxt = 4'd0;
    end else if (w_tick && bus.en) begin
      if (bus.up) begin
        if (r_ones == 4'd9) begin
          w_ones_nxt = 4'd0;
          if (r_tens == 4'd9) begin
            w_tens_nxt  = 4'd0;
            w_carry_nxt = 1'b1;
          end else begin
            w_tens_nxt = r_tens + 4'd1;
          end
        end else begin
          w_ones_nxt = r_ones + 4'd1;
        end
      end else begin
        if (r_ones == 4'd0) begin
          w_ones_nxt = 4'd9;
          if (r_tens == 4'd0) begin
            w_tens_nxt  = 4'd9;
            w_carry_nxt = 1'b1;
          end else begin
            w_tens_nxt = r_tens - 4'd1;
          end
        end else begin
          w_ones_nxt = r_ones - 4'd1;
        end
      end
    end
  end

  assign w_digit = r_sel ? r_tens : r_ones;

  always_comb begin
    w_seg_hi = 8'h00;
    case (w_digit)
      4'd0:    w_seg_hi = 8'h3F;
      4'd1:    w_seg_hi = 8'h06;
      4'd2:    w_seg_hi = 8'h5B;
      4'd3:    w_seg_hi = 8'h4F;
      4'd4:    w_seg_hi = 8'h66;
      4'd5:    w_seg_hi = 8'h6D;
      4'd6:    w_seg_hi = 8'h7D;
      4'd7:    w_seg_hi = 8'h07;
      4'd8:    w_seg_hi = 8'h7F;
      4'd9:    w_seg_hi = 8'h6F;
      default: w_seg_hi = 8'h00;
    endcase
`ifdef SEG_LZ_BLANK_EN
    if (r_sel && (r_tens == 4'd0)) begin
      w_seg_hi = 8'h00;
    end
`endif
  end

  assign w_seg_out = SEG_ACT_LOW ? ~w_seg_hi : w_seg_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b1;
      r_ones  <= 4'd0;
      r_tens  <= 4'd0;
      r_carry <= 1'b0;
    end else begin
      r_prev  <= bus.clk_1hz;
      r_ones  <= w_ones_nxt;
      r_tens  <= w_tens_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  // seg and dig_sel share one register stage so a slot change never shows the wrong digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= 16'd0;
      r_sel      <= 1'b0;
      r_seg      <= SEG_OFF;
      r_dig_sel  <= 2'b00;
    end else begin
      if (r_scan_cnt == SCAN_LAST) begin
        r_scan_cnt <= 16'd0;
        r_sel      <= ~r_sel;
      end else begin
        r_scan_cnt <= r_scan_cnt + 16'd1;
      end
      r_seg     <= w_seg_out;
      r_dig_sel <= r_sel ? 2'b10 : 2'b01;
    end
  end

  assign bus.seg     = r_seg;
  assign bus.dig_sel = r_dig_sel;
  assign bus.carry   = r_carry;

endmodule

// File: tb/tb_seg_bcd_counter.sv
// tb/tb_seg_bcd_counter.sv - self-checking bench for seg_bcd_counter (active-low and active-high instances)
module tb_seg_bcd_counter;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_bcd_counter_if ifa();
  seg_bcd_counter_if ifb();

  assign ifb.clk_1hz = ifa.clk_1hz;
  assign ifb.en      = ifa.en;
  assign ifb.clr     = ifa.clr;
  assign ifb.up      = ifa.up;

  seg_bcd_counter #(.SCAN_DIV(SD), .SEG_ACT_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );
  seg_bcd_counter #(.SCAN_DIV(SD), .SEG_ACT_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  typedef struct {
    bit clr;
    bit en;
    bit up;
    int pulses;
    int ones;
    int tens;
    bit carry;
  } vec_t;

  int total = 0;
  int bad = 0;
  int carry_seen = 0;
  bit exp_q[$];
  vec_t vecs[9];

  always @(negedge clk) begin
    if (rst_n && ifa.carry === 1'b1) carry_seen++;
  end

  function automatic logic [7:0] enc(int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(bit low, bit tens_slot, int ones, int tens);
    logic [7:0] v;
    v = enc(tens_slot ? tens : ones);
`ifdef SEG_LZ_BLANK_EN
    if (tens_slot && tens == 0) v = 8'h00;
`endif
    return low ? ~v : v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clk_1hz rising edge; called and returns just after a falling clk edge.
  task automatic tick(bit exp_carry);
    bit c;
    exp_q.push_back(exp_carry);
    ifa.clk_1hz = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c = exp_q.pop_front();
    check("carry_a", ifa.carry, c);
    check("carry_b", ifb.carry, c);
    ifa.clk_1hz = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic show_check(string name, int ones, int tens);
    logic [7:0] sa1, sa10, sb1, sb10;
    bit got1, got10;
    got1 = 0;
    got10 = 0;
    sa1 = 0; sa10 = 0; sb1 = 0; sb10 = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4 * SD + 4 && !(got1 && got10); i++) begin
      @(negedge clk);
      if (ifa.dig_sel == 2'b01) begin
        got1 = 1; sa1 = ifa.seg; sb1 = ifb.seg;
      end else if (ifa.dig_sel == 2'b10) begin
        got10 = 1; sa10 = ifa.seg; sb10 = ifb.seg;
      end
    end
    check({name, "_scan_seen"}, {got1, got10}, 2'b11);
    check({name, "_ones_a"}, sa1, exp_seg(1'b1, 1'b0, ones, tens));
    check({name, "_tens_a"}, sa10, exp_seg(1'b1, 1'b1, ones, tens));
    check({name, "_ones_b"}, sb1, exp_seg(1'b0, 1'b0, ones, tens));
    check({name, "_tens_b"}, sb10, exp_seg(1'b0, 1'b1, ones, tens));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 1, 0, 1, 9, 9, 1};
    vecs[1] = '{0, 1, 0, 1, 8, 9, 0};
    vecs[2] = '{0, 1, 1, 1, 9, 9, 0};
    vecs[3] = '{0, 1, 1, 1, 0, 0, 1};
    vecs[4] = '{1, 1, 1, 0, 0, 0, 0};
    vecs[5] = '{0, 1, 1, 37, 7, 3, 0};
    vecs[6] = '{1, 1, 1, 1, 0, 0, 0};
    vecs[7] = '{0, 0, 1, 3, 0, 0, 0};
    vecs[8] = '{0, 1, 1, 5, 5, 0, 0};

    ifa.clk_1hz = 1'b1;
    ifa.en = 1'b1;
    ifa.clr = 1'b0;
    ifa.up = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dig_sel", ifa.dig_sel, 2'b00);
    check("rst_seg_a", ifa.seg, 8'hFF);
    check("rst_seg_b", ifb.seg, 8'h00);
    check("rst_carry", ifa.carry, 1'b0);

    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      bit s;
      @(negedge clk);
      s = ((k - 1) / SD) % 2;
      check("scan_dig_sel", ifa.dig_sel, s ? 2'b10 : 2'b01);
      check("scan_seg_a", ifa.seg, exp_seg(1'b1, s, 0, 0));
    end
    ifa.clk_1hz = 1'b0;
    @(negedge clk);
    show_check("held_high", 0, 0);

    for (int i = 1; i <= 100; i++) begin
      tick(i == 100);
      if (i == 99) show_check("up_99", 9, 9);
    end
    show_check("up_wrap", 0, 0);

    for (int r = 0; r < 9; r++) begin
      ifa.clr = vecs[r].clr;
      ifa.en = vecs[r].en;
      ifa.up = vecs[r].up;
      if (vecs[r].pulses == 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      for (int p = 0; p < vecs[r].pulses; p++) tick((p == vecs[r].pulses - 1) ? vecs[r].carry : 1'b0);
      ifa.clr = 1'b0;
      show_check($sformatf("vec%0d", r), vecs[r].ones, vecs[r].tens);
    end

    ifa.en = 1'b0;
    ifa.clk_1hz = 1'b1;
    repeat (3) @(negedge clk);
    ifa.en = 1'b1;
    repeat (3) @(negedge clk);
    ifa.clk_1hz = 1'b0;
    show_check("en_late", 5, 0);

    ifa.clr = 1'b1;
    @(negedge clk);
    ifa.clr = 1'b0;
    for (int i = 1; i <= 42; i++) tick(1'b0);
    show_check("show_42", 2, 4);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dig_sel", ifa.dig_sel, 2'b00);
    check("midrst_seg_a", ifa.seg, 8'hFF);
    check("midrst_seg_b", ifb.seg, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_dig_sel", ifa.dig_sel, 2'b01);
    check("post_rst_seg_a", ifa.seg, 8'hC0);
    show_check("post_rst", 0, 0);

    check("carry_pulses", carry_seen, 3);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
